// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Request-to-send, device-clocked frame shift, ACK check and inter-edge timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_last;
    logic [9:0]    frame;
    logic [3:0]    idx;
    logic [CW-1:0] cnt;
    logic          ack_flag;
    logic          fe;
    logic          lines_idle;

    assign fe         = clk_last & ~clk_sync[1];
    assign lines_idle = clk_sync[1] & data_sync[1];

    // Pin synchronizers idle high, matching a released open-drain bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_last  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_last  <= clk_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        done    <= 1'b0;
        timeout <= 1'b0;
        ack_err <= 1'b0;
        if (rst) begin
            state       <= IDLE;
            frame       <= '0;
            idx         <= '0;
            cnt         <= '0;
            ack_flag    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    ps2_clk_oe <= 1'b0;
                    idx        <= '0;
                    cnt        <= '0;
                    state      <= SEND;
                end
                default: begin
                    // Completion wins over a coincident timeout expiry.
                    if (state == WAIT_IDLE && lines_idle) begin
                        done     <= 1'b1;
                        ack_err  <= ack_flag;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (fe) begin
                        cnt <= '0;
                        if (state == SEND) begin
                            ps2_data_oe <= ~frame[idx];
                            idx         <= idx + 1'b1;
                            if (idx == 4'd9) begin
                                state <= ACK;
                            end
                        end else if (state == ACK) begin
                            ack_flag <= data_sync[1];
                            state    <= WAIT_IDLE;
                        end
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        timeout     <= 1'b1;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TO  = 300;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(clk_line), .ps2_data_in(data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int stop_after = 0;
    bit dev_ack = 1'b1;
    int fall_cyc = 0;
    logic [10:0] dev_frame = '0;

    typedef struct {
        bit          is_to;
        bit          ack_err;
        logic [10:0] frame;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!rst && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Device: answers a request-to-send, clocks the frame, records samples on rising edges.
    initial forever begin
        @(negedge ps2_clk_oe);
        if (data_line === 1'b0) begin
            repeat (10) @(negedge clk);
            dev_frame[0] = data_line;
            for (int k = 1; k <= 10; k++) begin
                if (stop_after != 0 && k > stop_after) break;
                dev_clk = 1'b0;
                fall_cyc = cyc;
                repeat (H) @(negedge clk);
                dev_clk = 1'b1;
                dev_frame[k] = data_line;
                repeat (H) @(negedge clk);
            end
            if (stop_after == 0) begin
                if (dev_ack) dev_data = 1'b0;
                repeat (4) @(negedge clk);
                dev_clk = 1'b0;
                repeat (H) @(negedge clk);
                dev_clk = 1'b1;
                repeat (2) @(negedge clk);
                dev_data = 1'b1;
            end
        end
    end

    // Monitor: every done/timeout pulse is matched against the oldest expectation.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (done || timeout) begin
            if (done) done_cnt++;
            chk("done_timeout_exclusive", int'(done & timeout), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=done%0b/timeout%0b expected=none", done, timeout);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind_timeout", int'(timeout), int'(e.is_to));
                if (!e.is_to) begin
                    chk("ack_err", int'(ack_err), int'(e.ack_err));
                    chk("frame_bits", int'(dev_frame), int'(e.frame));
                end else begin
                    chk("timeout_interval", cyc - fall_cyc, TO + 3);
                    chk("timeout_release", int'({ps2_clk_oe, ps2_data_oe}), 0);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic par, input bit no_ack,
                        input int stop, input bit hold);
        logic [10:0] f;
        logic        last;
        int          w;
        int          n;
        f = {1'b1, par, d, 1'b0};
        dev_ack = !no_ack;
        stop_after = stop;
        exp_q.push_back('{stop != 0, no_ack, f});
        @(negedge clk);
        tx_data = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
        else tx_data = 8'($urandom);
        chk("clk_oe_after_accept", int'(ps2_clk_oe), 1);
        w = 0;
        last = 1'b0;
        while (ps2_clk_oe && w < 5000) begin
            last = ps2_data_oe;
            w++;
            @(posedge clk);
            #1;
            if (hold) tx_data = 8'($urandom);
        end
        chk("clk_low_cycles", w, INH + 1);
        chk("start_bit_at_release", int'(last), 1);
        n = 0;
        while (!tx_ready && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
            if (hold) tx_data = 8'($urandom);
        end
        tx_valid = 1'b0;
        chk("frame_end_ready", int'(tx_ready), 1);
        repeat (3 * H) @(posedge clk);
    endtask

    initial begin
        int a0;
        int d0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clk_oe", int'(ps2_clk_oe), 0);
        chk("rst_data_oe", int'(ps2_data_oe), 0);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'({done, ack_err, timeout}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while the clock line is held low.
        @(negedge clk);
        tx_data = 8'h12;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_inhibit_clk_oe", int'(ps2_clk_oe), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("mid_rst_ready_busy", int'({tx_ready, busy}), 2);
        chk("mid_rst_pulses", int'({done, timeout}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        send(8'hED, 1'b1, 1'b0, 0, 1'b0);
        send(8'h01, 1'b0, 1'b0, 0, 1'b0);
        send(8'h00, 1'b1, 1'b0, 0, 1'b0);
        send(8'hFF, 1'b1, 1'b0, 0, 1'b0);
        send(8'h55, 1'b1, 1'b1, 0, 1'b0);
        send(8'hA5, 1'b1, 1'b0, 4, 1'b0);
        chk("after_timeout_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);

        a0 = acc_cnt;
        d0 = done_cnt;
        send(8'h3C, 1'b1, 1'b0, 0, 1'b1);
        chk("hold_accepts", acc_cnt - a0, 1);
        chk("hold_dones", done_cnt - d0, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

endmodule
